// File: rtl/valid_burst_gen.sv
// Burst strobe source for the downstream counter: emits exactly count_in single-cycle
// strobes per load, with an optional fixed idle gap between strobes and hold-based pausing.
module valid_burst_gen #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] count_in,
    input  logic             hold,
    output logic             validtocounter,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Gap counter is kept at least one bit wide so GAP=0 still elaborates cleanly.
    localparam int            GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

    logic [1:0]       r_state;
    logic             r_vtc;
    logic [WIDTH-1:0] r_rem;
    logic             r_busy;
    logic             r_done;
    logic [GW-1:0]    r_gap;

    logic [1:0]       w_state_next;
    logic             w_vtc_next;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic [GW-1:0]    w_gap_next;

    always_comb begin
        w_state_next = r_state;
        w_vtc_next   = r_vtc;
        w_rem_next   = r_rem;
        w_busy_next  = r_busy;
        w_done_next  = r_done;
        w_gap_next   = r_gap;

        case (r_state)
            S_IDLE: begin
                w_vtc_next  = 1'b0;
                w_done_next = 1'b0;
                if (load) begin
                    if (count_in != '0) begin
                        w_rem_next   = count_in;
                        w_busy_next  = 1'b1;
                        w_state_next = S_RUN;
                    end else begin
                        // Empty burst completes immediately without ever going busy.
                        w_done_next = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (hold) begin
                    w_vtc_next = 1'b0;
                end else begin
                    w_vtc_next = 1'b1;
                    w_rem_next = r_rem - WIDTH'(1);
                    if (r_rem == WIDTH'(1)) begin
                        w_state_next = S_DONE;
                    end else if (GAP > 0) begin
                        w_gap_next   = GAP_LOAD;
                        w_state_next = S_GAP;
                    end
                end
            end

            S_GAP: begin
                w_vtc_next = 1'b0;
                if (!hold) begin
                    w_gap_next = r_gap - GW'(1);
                    if (r_gap == GW'(1)) begin
                        w_state_next = S_RUN;
                    end
                end
            end

            S_DONE: begin
                w_vtc_next   = 1'b0;
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end

            default: begin
                w_vtc_next   = 1'b0;
                w_done_next  = 1'b0;
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_vtc   <= 1'b0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_next;
            r_vtc   <= w_vtc_next;
            r_rem   <= w_rem_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_gap   <= w_gap_next;
        end
    end

    assign validtocounter = r_vtc;
    assign remaining      = r_rem;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
